// File: rtl/mimo_pkg.sv
// Shared constants and loader state type for the 4x4 QR MIMO detector datapath.
package mimo_pkg;
    localparam int unsigned W_DATA   = 28;
    localparam int unsigned N_ANT    = 4;
    localparam int unsigned NW_FRAME = 2*N_ANT + 2*N_ANT*N_ANT;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } loader_state_t;
endpackage

// File: rtl/frame_bank.sv
// NW x W register file for one frame: single indexed write port, whole contents on a flat read bus.
module frame_bank #(
    parameter int unsigned W  = 28,
    parameter int unsigned NW = 40,
    parameter int unsigned IW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [IW-1:0]   widx,
    input  logic [W-1:0]    wdata,
    output logic [NW*W-1:0] rdata
);
    logic [NW*W-1:0] mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else begin
            for (int unsigned i = 0; i < NW; i++) begin
                if (we && widx == IW'(i))
                    mem[i*W +: W] <= wdata;
            end
        end
    end

    assign rdata = mem;
endmodule

// File: rtl/mimo_frame_loader.sv
// Serial-to-parallel frame loader feeding the combinational MIMO detector (y vector, then H row-major).
// Optional ping-pong double buffering when FRAME_LOADER_PINGPONG_EN is defined.
module mimo_frame_loader #(
    parameter int unsigned W     = mimo_pkg::W_DATA,
    parameter int unsigned N_ANT = mimo_pkg::N_ANT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_sof,
    input  logic [W-1:0]             s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [2*N_ANT*W-1:0]     m_y,
    output logic [2*N_ANT*N_ANT*W-1:0] m_h,
    output logic                     err_sof
);
    import mimo_pkg::*;

    localparam int unsigned NY = 2*N_ANT;
    localparam int unsigned NW = NY + 2*N_ANT*N_ANT;
    localparam int unsigned IW = $clog2(NW);
    localparam logic [IW-1:0] LAST = IW'(NW-1);

    loader_state_t   state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   widx;
    logic            xfer;
    logic            rel;
    logic            done;
    logic [NW*W-1:0] rd_a;

    always_comb begin
        xfer = s_valid && s_ready;
        rel  = m_valid && m_ready;
        widx = s_sof ? '0 : idx;
        done = xfer && !s_sof && state == LOAD && idx == LAST;
    end

`ifdef FRAME_LOADER_PINGPONG_EN
    // wsel: bank being loaded; rsel: oldest full bank, i.e. the one presented.
    logic            wsel;
    logic            rsel;
    logic [1:0]      full;
    logic [1:0]      full_n;
    logic            we_any;
    logic [NW*W-1:0] rd_b;

    always_comb begin
        we_any = xfer && (s_sof || state == LOAD);
        full_n = full;
        if (done)
            full_n[wsel] = 1'b1;
        if (rel)
            full_n[rsel] = 1'b0;
    end

    frame_bank #(.W(W), .NW(NW), .IW(IW)) u_bank_a (
        .clk(clk), .rst(rst), .we(we_any && !wsel), .widx(widx), .wdata(s_data), .rdata(rd_a)
    );
    frame_bank #(.W(W), .NW(NW), .IW(IW)) u_bank_b (
        .clk(clk), .rst(rst), .we(we_any && wsel), .widx(widx), .wdata(s_data), .rdata(rd_b)
    );

    assign m_y = rsel ? rd_b[NY*W-1:0]    : rd_a[NY*W-1:0];
    assign m_h = rsel ? rd_b[NW*W-1:NY*W] : rd_a[NW*W-1:NY*W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            err_sof <= 1'b0;
            full    <= '0;
            wsel    <= 1'b0;
            rsel    <= 1'b0;
        end else begin
            err_sof <= 1'b0;
            full    <= full_n;
            m_valid <= |full_n;
            if (rel)
                rsel <= ~rsel;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (xfer) begin
                        if (s_sof) begin
                            idx   <= IW'(1);
                            state <= LOAD;
                        end else begin
                            err_sof <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (s_sof) begin
                            idx     <= IW'(1);
                            err_sof <= 1'b1;
                        end else if (idx == LAST) begin
                            idx  <= '0;
                            wsel <= ~wsel;
                            if (&full_n) begin
                                state   <= HOLD;
                                s_ready <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (rel) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic we;

    always_comb begin
        we = xfer && (s_sof || state == LOAD);
    end

    frame_bank #(.W(W), .NW(NW), .IW(IW)) u_bank_a (
        .clk(clk), .rst(rst), .we(we), .widx(widx), .wdata(s_data), .rdata(rd_a)
    );

    assign m_y = rd_a[NY*W-1:0];
    assign m_h = rd_a[NW*W-1:NY*W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            err_sof <= 1'b0;
        end else begin
            err_sof <= 1'b0;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (xfer) begin
                        if (s_sof) begin
                            idx   <= IW'(1);
                            state <= LOAD;
                        end else begin
                            err_sof <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (s_sof) begin
                            idx     <= IW'(1);
                            err_sof <= 1'b1;
                        end else if (done) begin
                            idx     <= '0;
                            state   <= HOLD;
                            s_ready <= 1'b0;
                            m_valid <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (rel) begin
                        state   <= IDLE;
                        s_ready <= 1'b1;
                        m_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_mimo_frame_loader.sv
// Directed bench for mimo_frame_loader; inputs driven and outputs sampled on the falling edge.
module tb_mimo_frame_loader;
    localparam int unsigned W  = mimo_pkg::W_DATA;
    localparam int unsigned NA = mimo_pkg::N_ANT;
    localparam int unsigned NW = 2*NA + 2*NA*NA;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic                   s_sof = 1'b0;
    logic [W-1:0]           s_data = '0;
    logic                   m_valid;
    logic                   m_ready = 1'b0;
    logic [2*NA*W-1:0]      m_y;
    logic [2*NA*NA*W-1:0]   m_h;
    logic                   err_sof;

    int checks   = 0;
    int failures = 0;

    mimo_frame_loader #(.W(W), .N_ANT(NA)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_h(m_h),
        .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] yw(input int k);
        return 64'(m_y[k*W +: W]);
    endfunction

    function automatic logic [63:0] hw(input int k);
        return 64'(m_h[k*W +: W]);
    endfunction

    // Called on a falling edge; returns on the falling edge after the word was accepted.
    task automatic push(input int d, input logic sof, input logic gap);
        int n = 0;
        s_valid = 1'b1;
        s_data  = W'(d);
        s_sof   = sof;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready)
            check("push_timeout", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        if (gap)
            @(negedge clk);
    endtask

    task automatic release_frame();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_y_zero", 64'(m_y == '0), 64'd1);
        check("rst_m_h_zero", 64'(m_h == '0), 64'd1);
        check("rst_err_sof", 64'(err_sof), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_s_ready_rise", 64'(s_ready), 64'd1);

        // 2. nominal back-to-back frame, data = k+1
        for (int k = 0; k < NW - 1; k++)
            push(k + 1, k == 0, 1'b0);
        check("nom_m_valid_early", 64'(m_valid), 64'd0);
        push(NW, 1'b0, 1'b0);
        check("nom_m_valid", 64'(m_valid), 64'd1);
        check("nom_y0", yw(0), 64'd1);
        check("nom_y7", yw(7), 64'd8);
        check("nom_h0", hw(0), 64'd9);
        check("nom_h31", hw(31), 64'd40);
        check("nom_err_sof", 64'(err_sof), 64'd0);
        release_frame();
        check("nom_rel_m_valid", 64'(m_valid), 64'd0);
        check("nom_rel_s_ready", 64'(s_ready), 64'd1);

        // 3. stalled frame with gaps, data = 100+k
        for (int k = 0; k < NW; k++)
            push(100 + k, k == 0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            check("stall_m_valid", 64'(m_valid), 64'd1);
`ifndef FRAME_LOADER_PINGPONG_EN
            check("stall_s_ready", 64'(s_ready), 64'd0);
`endif
            check("stall_y3", yw(3), 64'd103);
            check("stall_h5", hw(5), 64'd113);
            @(negedge clk);
        end
        release_frame();
        check("stall_rel_m_valid", 64'(m_valid), 64'd0);
        check("stall_rel_s_ready", 64'(s_ready), 64'd1);

        // 4. framing errors
        push(32'h55, 1'b0, 1'b0);
        check("drop_err_sof", 64'(err_sof), 64'd1);
        @(negedge clk);
        check("drop_err_sof_pulse", 64'(err_sof), 64'd0);
        check("drop_m_valid", 64'(m_valid), 64'd0);
`ifndef FRAME_LOADER_PINGPONG_EN
        check("drop_y0_kept", yw(0), 64'd100);
`endif
        for (int k = 0; k < 20; k++)
            push(200 + k, k == 0, 1'b0);
        push(300, 1'b1, 1'b0);
        check("restart_err_sof", 64'(err_sof), 64'd1);
        for (int k = 1; k < NW - 1; k++)
            push(300 + k, 1'b0, 1'b0);
        check("restart_err_clear", 64'(err_sof), 64'd0);
        check("restart_m_valid_early", 64'(m_valid), 64'd0);
        push(300 + NW - 1, 1'b0, 1'b0);
        check("restart_m_valid", 64'(m_valid), 64'd1);
        check("restart_y0", yw(0), 64'd300);
        check("restart_y1", yw(1), 64'd301);
        check("restart_h31", hw(31), 64'd339);
        release_frame();

        // 5. reset during LOAD at word 15
        for (int k = 0; k < 15; k++)
            push(400 + k, k == 0, 1'b0);
        s_valid = 1'b1;
        s_data  = W'(415);
        rst     = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd0);
        check("mid_rst_y0", yw(0), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NW; k++)
            push(500 + k, k == 0, 1'b0);
        check("post_rst_m_valid", 64'(m_valid), 64'd1);
        check("post_rst_y0", yw(0), 64'd500);
        check("post_rst_y7", yw(7), 64'd507);
        check("post_rst_h0", hw(0), 64'd508);
        check("post_rst_h31", hw(31), 64'd539);
        release_frame();
        check("post_rst_rel", 64'(m_valid), 64'd0);

`ifdef FRAME_LOADER_PINGPONG_EN
        // 6. two frames queued, then drained in order
        for (int k = 0; k < NW; k++)
            push(600 + k, k == 0, 1'b0);
        check("pp_first_s_ready", 64'(s_ready), 64'd1);
        for (int k = 0; k < NW; k++)
            push(700 + k, k == 0, 1'b0);
        check("pp_full_s_ready", 64'(s_ready), 64'd0);
        check("pp_full_m_valid", 64'(m_valid), 64'd1);
        check("pp_f1_y0", yw(0), 64'd600);
        check("pp_f1_h31", hw(31), 64'd639);
        release_frame();
        check("pp_cont_m_valid", 64'(m_valid), 64'd1);
        check("pp_f2_y0", yw(0), 64'd700);
        check("pp_f2_h31", hw(31), 64'd739);
        check("pp_free_s_ready", 64'(s_ready), 64'd1);
        release_frame();
        check("pp_empty_m_valid", 64'(m_valid), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
